// File: rtl/control_sequencer.sv
// ---------------------------------------------------------------------------
// control_sequencer
//
// Purpose: a small fetch/decode/execute controller for an 8-bit accumulator
// machine. Instructions are 8 bits wide: opcode in [7:6], operand address in
// [5:0]. The sequencer does not own the PC or the accumulator. It drives the
// strobes that tell those blocks what to do, and it runs the memory
// read/write handshake. A watchdog aborts any memory access that never
// completes.
//
// Ports:
//   clk          single clock, rising edge
//   reset        synchronous, active-low
//   start        begin from IDLE, or resume from HALT
//   halt_req     stop at the next instruction boundary
//   mem_rdata    memory read data (valid with mem_ready during a read)
//   mem_ready    memory handshake completion
//   mem_rd       memory read request
//   mem_wr       memory write request (accumulator store)
//   addr_sel     memory address source: 0 = PC, 1 = IR[5:0]
//   loadPC       PC load strobe (jump)
//   incPC        PC increment strobe
//   pc_clr       PC clear strobe
//   address      jump/operand target, always IR[5:0]
//   acc_load     accumulator load strobe
//   alu_add      accumulator source: 1 = ALU sum, 0 = mem_rdata
//   busy         high in FETCH, DECODE and EXEC
//   halted       high in HALT
//   err          sticky memory-timeout flag
//   state        current state encoding
//   instr_count  retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
module control_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       halt_req,
    input  logic [7:0] mem_rdata,
    input  logic       mem_ready,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       addr_sel,
    output logic       loadPC,
    output logic       incPC,
    output logic       pc_clr,
    output logic [5:0] address,
    output logic       acc_load,
    output logic       alu_add,
    output logic       busy,
    output logic       halted,
    output logic       err,
    output logic [2:0] state,
    output logic [7:0] instr_count
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    localparam logic [1:0] OP_LDA = 2'b00;
    localparam logic [1:0] OP_STA = 2'b01;
    localparam logic [1:0] OP_ADD = 2'b10;
    localparam logic [1:0] OP_JMP = 2'b11;

    // The watchdog holds the number of wait cycles already spent in the
    // current access. A wait cycle seen while it holds 14 would take it to
    // 15, so that cycle is the 15th consecutive wait and aborts the access.
    localparam logic [3:0] WD_LAST = 4'd14;

    state_t     state_q, state_d;
    logic [7:0] ir_q, ir_d;
    logic [7:0] instr_count_q, instr_count_d;
    logic [3:0] wd_q, wd_d;
    logic       err_q, err_d;

    logic [1:0] opcode;

    assign opcode = ir_q[7:6];

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            ir_q          <= 8'h00;
            instr_count_q <= 8'h00;
            wd_q          <= 4'd0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            ir_q          <= ir_d;
            instr_count_q <= instr_count_d;
            wd_q          <= wd_d;
            err_q         <= err_d;
        end
    end

    // Next-state logic. The watchdog defaults to zero. It only counts up
    // while a FETCH/EXEC access keeps waiting, so it always starts from
    // zero when either state is entered.
    always_comb begin
        state_d       = state_q;
        ir_d          = ir_q;
        instr_count_d = instr_count_q;
        wd_d          = 4'd0;
        err_d         = err_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    state_d = ST_DECODE;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 4'd1;
                end
            end

            ST_DECODE: begin
                if (opcode == OP_JMP) begin
                    instr_count_d = instr_count_q + 8'd1;
                    state_d       = halt_req ? ST_HALT : ST_FETCH;
                end else begin
                    state_d = ST_EXEC;
                end
            end

            ST_EXEC: begin
                if (mem_ready) begin
                    instr_count_d = instr_count_q + 8'd1;
                    state_d       = halt_req ? ST_HALT : ST_FETCH;
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_HALT;
                    err_d   = 1'b1;
                end else begin
                    wd_d = wd_q + 4'd1;
                end
            end

            ST_HALT: begin
                // A resume does not clear the PC, and it clears the
                // timeout flag.
                if (start && !halt_req) begin
                    state_d = ST_FETCH;
                    err_d   = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. Every strobe and status bit is gated by reset. While
    // reset is held, the old state is still in the register, and it must
    // not leak out as a strobe.
    always_comb begin
        mem_rd   = 1'b0;
        mem_wr   = 1'b0;
        addr_sel = 1'b0;
        loadPC   = 1'b0;
        incPC    = 1'b0;
        pc_clr   = 1'b0;
        acc_load = 1'b0;
        alu_add  = 1'b0;
        busy     = 1'b0;
        halted   = 1'b0;

        if (reset) begin
            case (state_q)
                ST_IDLE: begin
                    pc_clr = start;
                end

                ST_FETCH: begin
                    busy   = 1'b1;
                    mem_rd = 1'b1;
                    incPC  = mem_ready;
                end

                ST_DECODE: begin
                    busy   = 1'b1;
                    loadPC = (opcode == OP_JMP);
                end

                ST_EXEC: begin
                    busy     = 1'b1;
                    addr_sel = 1'b1;
                    if (opcode == OP_STA) begin
                        mem_wr = 1'b1;
                    end else begin
                        mem_rd   = 1'b1;
                        acc_load = mem_ready;
                        alu_add  = mem_ready && (opcode == OP_ADD);
                    end
                end

                ST_HALT: begin
                    halted = 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

    assign address     = ir_q[5:0];
    assign state       = state_q;
    assign instr_count = instr_count_q;
    assign err         = err_q;

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL have no parameters; widths fixed: 8-bit instruction, 2-bit opcode [7:6], 6-bit address [5:0].
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low; sampled on rising clk edge.
REQ-004 start  input  1  begin execution (from IDLE) or resume (from HALT).
REQ-005 halt_req  input  1  request stop at next instruction boundary.
REQ-006 mem_rdata  input  8  memory read data; valid when mem_ready=1 during a read.
REQ-007 mem_ready  input  1  memory handshake completion, one-cycle pulse or held.
REQ-008 mem_rd  output  1  memory read request.
REQ-009 mem_wr  output  1  memory write request (accumulator store).
REQ-010 addr_sel  output  1  memory address source: 0 = PC value, 1 = IR[5:0].
REQ-011 loadPC  output  1  PC load strobe.
REQ-012 incPC  output  1  PC increment strobe.
REQ-013 pc_clr  output  1  PC clear strobe, drives the PC reset input.
REQ-014 address  output  6  jump target; always equals IR[5:0].
REQ-015 acc_load  output  1  accumulator load strobe.
REQ-016 alu_add  output  1  accumulator source select: 1 = ALU sum, 0 = mem_rdata.
REQ-017 busy  output  1  high in FETCH, DECODE and EXEC.
REQ-018 halted  output  1  high in HALT.
REQ-019 err  output  1  sticky memory-timeout flag.
REQ-020 state  output  3  current state encoding.
REQ-021 instr_count  output  8  retired-instruction counter.

Function
REQ-022 States and encodings SHALL be: IDLE=0, FETCH=1, DECODE=2, EXEC=3, HALT=4; other codes SHALL return to IDLE on the next edge.
REQ-023 Opcodes SHALL be: 00 LDA (acc<=mem[a]), 01 STA (mem[a]<=acc), 10 ADD (acc<=acc+mem[a]), 11 JMP (PC<=a).
REQ-024 IDLE: all strobes 0; if start=1, pc_clr=1 combinationally this cycle and next state is FETCH.
REQ-025 FETCH: mem_rd=1, addr_sel=0; on mem_ready=1, the internal IR latches mem_rdata and incPC=1 in the same cycle, and the next state is DECODE.
REQ-026 DECODE, JMP: loadPC=1 for one cycle; the instruction retires; the next state is FETCH, or HALT if halt_req=1.
REQ-027 DECODE, other opcodes: no strobes; the next state is EXEC.
REQ-028 EXEC, LDA/ADD: mem_rd=1, addr_sel=1; on mem_ready=1, acc_load=1 with alu_add = (opcode==10), and the instruction retires.
REQ-029 EXEC, STA: mem_wr=1, addr_sel=1; the instruction retires on mem_ready=1.
REQ-030 On EXEC retire, the next state SHALL be FETCH, or HALT if halt_req=1 in the retire cycle.
REQ-031 halt_req outside a retire cycle SHALL have no effect; an instruction in flight always completes.
REQ-032 HALT: strobes 0, halted=1; start=1 with halt_req=0 goes to FETCH without pc_clr (resume); start with halt_req=1 stays in HALT.
REQ-033 Watchdog: a 4-bit counter SHALL clear on entry to FETCH or EXEC and increment each cycle mem_ready=0 in those states.
REQ-034 When the watchdog reaches 15 with mem_ready=0, the block SHALL go to HALT, set err=1, and suppress incPC and acc_load.
REQ-035 err SHALL clear only on reset or on a start-initiated exit from HALT.
REQ-036 instr_count SHALL increment by 1 on each retire and wrap from 255 to 0.
REQ-037 loadPC, incPC and pc_clr SHALL be mutually exclusive in every cycle; mem_rd and mem_wr SHALL never both be 1.
REQ-038 mem_rd/mem_wr SHALL stay asserted with constant addr_sel until mem_ready or timeout.
REQ-039 mem_ready outside FETCH/EXEC SHALL be ignored.

Reset
REQ-040 With reset=0 at an edge: state=IDLE, IR=0x00, instr_count=0, watchdog=0, err=0.
REQ-041 While reset=0, all strobes SHALL be 0 and busy=0, halted=0; reset SHALL override start, halt_req and any in-flight handshake.
REQ-042 Reset mid-operation SHALL abandon the cycle in flight with no retire and no PC strobe.

Verification
REQ-043 Reset, then start=1 for 1 cycle -> pc_clr=1 that cycle; next cycle state=1, mem_rd=1, addr_sel=0.
REQ-044 FETCH, mem_rdata=0x85 (ADD 5), mem_ready after 2 cycles -> incPC=1 once; DECODE; EXEC: addr_sel=1, mem_rd=1; mem_ready -> acc_load=1, alu_add=1, instr_count=1.
REQ-045 Fetch 0xCA (JMP 10) -> DECODE: loadPC=1, address=6'd10, incPC=0; next state FETCH.
REQ-046 STA 0x47 with halt_req=1 during EXEC, mem_ready=1 -> mem_wr=1, retire, state=HALT, halted=1; start=1 -> FETCH with pc_clr=0.
REQ-047 FETCH with mem_ready held 0 -> after 15 wait cycles: state=HALT, err=1, incPC never asserted; start clears err.
REQ-048 Retire 256 JMP instructions -> instr_count wraps to 0; reset=0 asserted mid-EXEC -> state=IDLE, no strobe.
